// File: rtl/cafe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cafe_pkg
//  Brief    : Shared types and default phase timings for the brew sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package cafe_pkg;

    // Drink codes as offered by the credit FSM.
    typedef enum logic [1:0] {
        NONE       = 2'b00,
        EXPRESO    = 2'b01,
        CAPPUCCINO = 2'b10,
        AMERICANO  = 2'b11
    } drink_t;

    // Sequencer states.
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_CHECK = 4'd1,
        S_GRIND = 4'd2,
        S_HEAT  = 4'd3,
        S_PUMP  = 4'd4,
        S_MILK  = 4'd5,
        S_WATER = 4'd6,
        S_DONE  = 4'd7,
        S_FAULT = 4'd8
    } brew_state_t;

    // Default phase timings in clock cycles.
    localparam int C_DEF_CNT_W        = 8;
    localparam int C_DEF_GRIND_CYC    = 20;
    localparam int C_DEF_HEAT_TIMEOUT = 40;
    localparam int C_DEF_PUMP_CYC     = 30;
    localparam int C_DEF_MILK_CYC     = 25;
    localparam int C_DEF_WATER_CYC    = 50;

endpackage : cafe_pkg
`default_nettype wire

// File: rtl/cafe_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module   : cafe_phase_timer
//  Brief    : Loadable down-counter shared by all timed brew phases. Holds
//             at zero once expired.
//  Revision : 1.0 - initial release
// ============================================================================
module cafe_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load has priority; otherwise count down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule : cafe_phase_timer
`default_nettype wire

// File: rtl/cafe_brew_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cafe_brew_sequencer
//  Brief    : Runs one drink order through check, grind, heat, pump and the
//             optional milk / water phase, with abort and sticky faults.
//  Revision : 1.0 - initial release
// ============================================================================
module cafe_brew_sequencer
    import cafe_pkg::*;
#(
    parameter int CNT_W        = C_DEF_CNT_W,
    parameter int GRIND_CYC    = C_DEF_GRIND_CYC,
    parameter int HEAT_TIMEOUT = C_DEF_HEAT_TIMEOUT,
    parameter int PUMP_CYC     = C_DEF_PUMP_CYC,
    parameter int MILK_CYC     = C_DEF_MILK_CYC,
    parameter int WATER_CYC    = C_DEF_WATER_CYC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       order_valid_i,
    input  logic [1:0] order_drink_i,
    output logic       order_ready_o,
    input  logic       abort_i,
    input  logic       temp_ok_i,
    input  logic       water_low_i,
    output logic       grind_en_o,
    output logic       heat_en_o,
    output logic       pump_en_o,
    output logic       milk_en_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       fault_o
);

    brew_state_t      state_q, state_d;
    drink_t           drink_q;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;
    logic             order_ready_q, grind_q, heat_q, pump_q, milk_q;
    logic             busy_q, done_q, fault_q;

    cafe_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // Next-state selection; abort overrides every other exit condition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (order_valid_i && (order_drink_i != NONE)) state_d = S_CHECK;
            S_CHECK: state_d = water_low_i ? S_FAULT : S_GRIND;
            S_GRIND: if (tmr_zero) state_d = S_HEAT;
            S_HEAT: begin
                if (temp_ok_i)     state_d = S_PUMP;
                else if (tmr_zero) state_d = S_FAULT;
            end
            S_PUMP: begin
                if (water_low_i) begin
                    state_d = S_FAULT;
                end else if (tmr_zero) begin
                    unique case (drink_q)
                        CAPPUCCINO: state_d = S_MILK;
                        AMERICANO:  state_d = S_WATER;
                        default:    state_d = S_DONE;
                    endcase
                end
            end
            S_MILK:  if (tmr_zero) state_d = S_DONE;
            S_WATER: begin
                if (water_low_i)   state_d = S_FAULT;
                else if (tmr_zero) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
        if (abort_i && !(state_q inside {S_IDLE, S_DONE, S_FAULT})) begin
            state_d = S_IDLE;
        end
    end

    // Arm the shared timer with N-1 on entry to any timed phase.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (state_d != state_q) begin
            unique case (state_d)
                S_GRIND: begin tmr_load = 1'b1; tmr_val = CNT_W'(GRIND_CYC - 1);    end
                S_HEAT:  begin tmr_load = 1'b1; tmr_val = CNT_W'(HEAT_TIMEOUT - 1); end
                S_PUMP:  begin tmr_load = 1'b1; tmr_val = CNT_W'(PUMP_CYC - 1);     end
                S_MILK:  begin tmr_load = 1'b1; tmr_val = CNT_W'(MILK_CYC - 1);     end
                S_WATER: begin tmr_load = 1'b1; tmr_val = CNT_W'(WATER_CYC - 1);    end
                default: begin tmr_load = 1'b0; tmr_val = '0;                       end
            endcase
        end
    end

    // State, latched drink and Moore outputs registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            drink_q       <= NONE;
            order_ready_q <= 1'b1;
            grind_q       <= 1'b0;
            heat_q        <= 1'b0;
            pump_q        <= 1'b0;
            milk_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_IDLE) && (state_d == S_CHECK)) begin
                drink_q <= drink_t'(order_drink_i);
            end
            order_ready_q <= (state_d == S_IDLE);
            grind_q       <= (state_d == S_GRIND);
            heat_q        <= (state_d inside {S_HEAT, S_WATER});
            pump_q        <= (state_d inside {S_PUMP, S_WATER});
            milk_q        <= (state_d == S_MILK);
            busy_q        <= !(state_d inside {S_IDLE, S_FAULT});
            done_q        <= (state_d == S_DONE);
            fault_q       <= (state_d == S_FAULT);
        end
    end

    assign order_ready_o = order_ready_q;
    assign grind_en_o    = grind_q;
    assign heat_en_o     = heat_q;
    assign pump_en_o     = pump_q;
    assign milk_en_o     = milk_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign fault_o       = fault_q;

endmodule : cafe_brew_sequencer
`default_nettype wire

// File: tb/tb_cafe_brew_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cafe_brew_sequencer
//  Brief    : Scoreboard bench for the brew sequencer. Orders are modelled as
//             a per-cycle phase timeline; a monitor measures each brew and
//             compares it with the queued prediction.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cafe_brew_sequencer;

    localparam int GRIND_N = 20;
    localparam int HEAT_TO = 40;
    localparam int PUMP_N  = 30;
    localparam int MILK_N  = 25;
    localparam int WATER_N = 50;

    localparam int P_CHECK = 0, P_GRIND = 1, P_HEAT = 2, P_PUMP = 3;
    localparam int P_MILK  = 4, P_WATER = 5, P_DONE = 6, P_HFAULT = 7;
    localparam int O_DONE  = 0, O_FAULT = 1, O_ABORT = 2;

    typedef struct {
        int outcome;
        int term;
        int grind;
        int heat;
        int pump;
        int milk;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       order_valid = 1'b0;
    logic [1:0] order_drink = 2'b00;
    logic       abort = 1'b0;
    logic       temp_ok = 1'b0;
    logic       water_low = 1'b0;
    logic       order_ready, grind_en, heat_en, pump_en, milk_en, busy, done, fault;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cafe_brew_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .order_valid_i (order_valid),
        .order_drink_i (order_drink),
        .order_ready_o (order_ready),
        .abort_i       (abort),
        .temp_ok_i     (temp_ok),
        .water_low_i   (water_low),
        .grind_en_o    (grind_en),
        .heat_en_o     (heat_en),
        .pump_en_o     (pump_en),
        .milk_en_o     (milk_en),
        .busy_o        (busy),
        .done_o        (done),
        .fault_o       (fault)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: cycle c (1 = first cycle after accept) maps to a phase label.
    // temp_ok is high from cycle temp_at, water_low / abort pulse at wl_at /
    // ab_at (0 = never).
    function automatic exp_t model(input int drink, input int temp_at,
                                   input int wl_at, input int ab_at);
        int   tl[$];
        exp_t e;
        bit   hfault;
        e.outcome = O_DONE; e.term = 0; e.grind = 0;
        e.heat = 0; e.pump = 0; e.milk = 0;
        tl.push_back(P_CHECK);
        repeat (GRIND_N) tl.push_back(P_GRIND);
        hfault = 1'b1;
        for (int k = 0; k < HEAT_TO; k++) begin
            tl.push_back(P_HEAT);
            if (tl.size() >= temp_at) begin
                hfault = 1'b0;
                break;
            end
        end
        if (hfault) begin
            tl.push_back(P_HFAULT);
        end else begin
            repeat (PUMP_N) tl.push_back(P_PUMP);
            if (drink == 2) repeat (MILK_N) tl.push_back(P_MILK);
            if (drink == 3) repeat (WATER_N) tl.push_back(P_WATER);
            tl.push_back(P_DONE);
        end
        for (int i = 0; i < tl.size(); i++) begin
            int c;
            int p;
            c = i + 1;
            p = tl[i];
            if (p == P_DONE)   begin e.outcome = O_DONE;  e.term = c; break; end
            if (p == P_HFAULT) begin e.outcome = O_FAULT; e.term = c; break; end
            if (p == P_GRIND) e.grind++;
            if (p == P_HEAT || p == P_WATER) e.heat++;
            if (p == P_PUMP || p == P_WATER) e.pump++;
            if (p == P_MILK) e.milk++;
            if (c == ab_at) begin e.outcome = O_ABORT; e.term = c + 1; break; end
            if (c == wl_at && (p == P_CHECK || p == P_PUMP || p == P_WATER)) begin
                e.outcome = O_FAULT; e.term = c + 1; break;
            end
        end
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; order_valid = 1'b0; abort = 1'b0;
        temp_ok = 1'b0; water_low = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Offer one order, wait for acceptance; returns 0 if never accepted.
    task automatic offer(input int drink, output bit ok);
        int budget;
        @(negedge clk);
        order_valid = 1'b1; order_drink = 2'(drink);
        temp_ok = 1'b0; water_low = 1'b0; abort = 1'b0;
        budget = 0;
        while (!order_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        ok = order_ready;
        if (!ok) begin
            check("order_ready_wait", 0, 1);
            order_valid = 1'b0;
            do_reset();
        end
    endtask

    task automatic run_order(input int drink, input int temp_at,
                             input int wl_at, input int ab_at);
        exp_t e;
        bit   ok;
        e = model(drink, temp_at, wl_at, ab_at);
        offer(drink, ok);
        if (!ok) return;
        sb_q.push_back(e);
        @(posedge clk);
        for (int c = 1; c <= e.term + 1; c++) begin
            @(negedge clk);
            order_valid = 1'b0;
            temp_ok   = (c >= temp_at);
            water_low = (c == wl_at);
            abort     = (c == ab_at);
        end
        @(negedge clk);
        temp_ok = 1'b0; water_low = 1'b0; abort = 1'b0;
        if (e.outcome == O_FAULT) begin
            // Fault is sticky: new orders and abort must not move it.
            for (int k = 0; k < 3; k++) begin
                order_valid = 1'b1; order_drink = 2'b01; abort = 1'b1;
                @(negedge clk);
                check("fault_sticky", int'(fault), 1);
                check("fault_not_ready", int'(order_ready), 0);
                check("fault_enables_off",
                      int'(grind_en | heat_en | pump_en | milk_en | busy), 0);
            end
            do_reset();
        end
    endtask

    // Monitor: a rising busy marks an accepted order; the brew ends at the
    // done pulse, at fault, or when busy drops without either (abort).
    initial begin
        int   cyc, g, h, p, m, outc;
        bit   active, post_done, prev_busy, term;
        exp_t e;
        active = 0; post_done = 0; prev_busy = 0;
        cyc = 0; g = 0; h = 0; p = 0; m = 0; outc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                active = 0; post_done = 0; prev_busy = 0;
                continue;
            end
            if (post_done) begin
                post_done = 0;
                check("ready_after_done", int'(order_ready), 1);
                check("done_single_pulse", int'(done), 0);
            end
            if (!active && busy && !prev_busy) begin
                active = 1; cyc = 0; g = 0; h = 0; p = 0; m = 0;
            end
            if (active) begin
                cyc++;
                g += int'(grind_en); h += int'(heat_en);
                p += int'(pump_en);  m += int'(milk_en);
                term = 1;
                if (done)       outc = O_DONE;
                else if (fault) outc = O_FAULT;
                else if (!busy) outc = O_ABORT;
                else            term = 0;
                if (term) begin
                    active = 0;
                    if (sb_q.size() == 0) begin
                        check("unexpected_brew", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("outcome", outc, e.outcome);
                        check("end_cycle", cyc, e.term);
                        check("grind_cycles", g, e.grind);
                        check("heat_cycles", h, e.heat);
                        check("pump_cycles", p, e.pump);
                        check("milk_cycles", m, e.milk);
                    end
                    if (outc == O_DONE) post_done = 1;
                end else if (cyc > 400) begin
                    check("brew_timeout", cyc, 0);
                    active = 0;
                end
            end
            prev_busy = busy;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        // Reset values while reset is held.
        repeat (2) @(negedge clk);
        check("rst_order_ready", int'(order_ready), 1);
        check("rst_outputs", int'(grind_en | heat_en | pump_en | milk_en | busy | done | fault), 0);
        reset = 1'b0;

        // Directed scenarios from the brewing rules.
        run_order(1, 0, 0, 0);        // espresso, hot boiler: done at cycle 52
        run_order(2, 32, 0, 0);       // cappuccino, temp_ok 10 cycles into heat
        run_order(3, 0, 0, 0);        // americano
        run_order(1, 1000, 0, 0);     // boiler never ready: heat timeout fault
        run_order(1, 0, 27, 0);       // water_low at pump cycle 5
        run_order(1, 0, 0, 4);        // abort at grind cycle 3
        run_order(2, 0, 1, 0);        // water_low during check
        run_order(3, 0, 100, 0);      // water_low during water top-up

        // Code 00 is never accepted.
        @(negedge clk);
        order_valid = 1'b1; order_drink = 2'b00;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("none_not_busy", int'(busy), 0);
            check("none_still_ready", int'(order_ready), 1);
        end
        order_valid = 1'b0;

        // Asynchronous reset mid-grind drops everything without a clock edge.
        offer(1, ok);
        if (ok) begin
            repeat (10) @(negedge clk);
            order_valid = 1'b0;
            check("pre_reset_grinding", int'(grind_en), 1);
            reset = 1'b1;
            #1;
            check("async_rst_grind", int'(grind_en), 0);
            check("async_rst_busy", int'(busy), 0);
            check("async_rst_ready", int'(order_ready), 1);
            repeat (2) @(negedge clk);
            reset = 1'b0;
        end

        // Randomized orders.
        for (int n = 0; n < 40; n++) begin
            int drink, r, t_at, wl, ab;
            drink = int'($urandom_range(1, 3));
            r = int'($urandom_range(0, 9));
            if (r < 6)      t_at = int'($urandom_range(0, 30));
            else if (r < 8) t_at = int'($urandom_range(30, 61));
            else            t_at = int'($urandom_range(62, 70));
            wl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 140)) : 0;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 140)) : 0;
            run_order(drink, t_at, wl, ab);
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cafe_brew_sequencer
`default_nettype wire

// File: doc/cafe_brew_sequencer.md
Name: cafe_brew_sequencer

Overview:
Sequences the single brewing unit (grinder, heater, pump, milk frother) for one drink order at a time. Sits after the coin/credit FSM: once credit is sufficient, that FSM issues an order over a valid/ready handshake. This block drives the actuator enables with fixed phase timings, reports completion, and latches faults.

Parameters:
CNT_W, 8, width of phase down-counter; every *_CYC value must be ≤ 2^CNT_W.
GRIND_CYC, 20, grinder-on cycles.
HEAT_TIMEOUT, 40, maximum cycles waiting for temp_ok before fault.
PUMP_CYC, 30, espresso extraction cycles.
MILK_CYC, 25, frother-on cycles (cappuccino only).
WATER_CYC, 50, hot-water top-up cycles (americano only).

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
order_valid  in  1  order offered
order_drink  in  2  00 none, 01 espresso, 10 cappuccino, 11 americano
order_ready  out  1  block can accept an order
abort  in  1  cancel current brew
temp_ok  in  1  boiler at temperature
water_low  in  1  reservoir low
grind_en  out  1  grinder enable
heat_en  out  1  heater enable
pump_en  out  1  pump enable
milk_en  out  1  frother enable
busy  out  1  order in progress
done  out  1  one-cycle completion pulse
fault  out  1  sticky fault flag

Behaviour:
- Reset: state IDLE, counter 0, latched drink 00; all outputs 0 except order_ready=1.
- Moore outputs, decoded from the registered state only.
- States: IDLE, CHECK, GRIND, HEAT, PUMP, MILK, WATER, DONE, FAULT.
- order_ready=1 only in IDLE. A transfer occurs on a clk edge with order_valid & order_ready & (order_drink!=00). Code 00 is never accepted; the block stays in IDLE.
- On transfer: latch order_drink, go to CHECK. busy=1 in every state except IDLE and FAULT.
- CHECK (1 cycle): water_low -> FAULT; otherwise -> GRIND.
- Timed phases (GRIND, PUMP, MILK, WATER):
  - On entry, load counter with N-1 and decrement each cycle; leave when counter==0.
  - The enable is therefore high for exactly N cycles.
- GRIND: grind_en=1, N=GRIND_CYC, then -> HEAT.
- HEAT: heat_en=1. Load the counter with HEAT_TIMEOUT-1 on entry.
  - temp_ok sampled 1 -> PUMP.
  - Counter reaches 0 with temp_ok=0 -> FAULT.
  - Minimum 1 cycle in HEAT, maximum HEAT_TIMEOUT.
- PUMP: pump_en=1, N=PUMP_CYC. Exit by latched drink: espresso -> DONE, cappuccino -> MILK, americano -> WATER.
- MILK: milk_en=1, N=MILK_CYC, then -> DONE.
- WATER: pump_en=1 and heat_en=1, N=WATER_CYC, then -> DONE.
- DONE (1 cycle): done=1, then -> IDLE. A new order is accepted no earlier than the cycle after DONE.
- water_low=1 during PUMP or WATER -> FAULT on the next edge.
- FAULT: fault=1, all enables 0, order_ready=0. Exit only via reset; abort has no effect.
- abort=1 in any state except IDLE, DONE and FAULT -> IDLE on the next edge. No done pulse; all enables drop with the state change.
- Priority within a cycle: abort > water_low fault > phase timer/temp_ok.
- Espresso latency with temp_ok already high: accept edge, then CHECK 1 + GRIND 20 + HEAT 1 + PUMP 30 cycles. done asserts 52 cycles after the accept edge.
- Reset mid-brew: all enables drop immediately (asynchronous); the order is lost.

Decomposition:
- Package cafe_pkg:
  - drink_t enum: NONE, EXPRESO, CAPPUCCINO, AMERICANO, with codes 00/01/10/11.
  - brew_state_t enum.
  - Default cycle constants.
- One natural sub-module, cafe_phase_timer: load / decrement / zero flag, CNT_W wide. It is instantiated once and shared across all phases.

Test Plan:
- Espresso, temp_ok=1, water_low=0 -> grind_en high 20 cycles, heat_en 1 cycle, pump_en 30 cycles; done pulse exactly 52 cycles after accept; order_ready back to 1 the cycle after done.
- Cappuccino, temp_ok rises 10 cycles into HEAT -> heat_en high 11 cycles; milk_en high 25 cycles after pump; a single done pulse.
- Americano -> pump_en continuous for 30+50 cycles, with heat_en also high for the last 50; then done.
- temp_ok held 0 -> heat_en high 40 cycles, then fault=1; enables 0; order_ready=0 until reset; order_valid ignored.
- water_low asserted at PUMP cycle 5 -> pump_en drops next edge, fault=1; abort afterwards does not clear it.
- abort at GRIND cycle 3 -> IDLE next edge, no done; order_drink=00 with order_valid=1 -> no transfer, busy stays 0.
